turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Game-flow FSM that drives the turn rotator for Chicken Cha-Cha-Cha.
- Accepts a card pick from the current player and compares the card symbol with the track tile ahead of that player's chicken.
- On a match, the chicken advances and the player keeps the turn. On a miss, the card is shown for a hold time, then one `next_turn` strobe is issued.
- The block sits between the input/debounce logic and the turn rotator. It reads `turn` back from the rotator.

Parameters:
- NUM_CARDS, 12, number of face-down cards; pick_idx values >= NUM_CARDS are invalid.
- TRACK_LEN, 24, number of track tiles; positions wrap modulo TRACK_LEN.
- START_GAP, 6, start tile of player p is p*START_GAP.
- WIN_STEPS, 24, number of successful advances that wins the game.
- REVEAL_CYCLES, 8, clock cycles a picked card stays revealed; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; starts a new game from IDLE or WIN.
- n_players  in  2  00=2, 01=3, 10=4 players; 11 is treated as 4; sampled on start.
- turn  in  2  current player index from the turn rotator.
- pick_valid  in  1  single-cycle strobe for a card pick.
- pick_idx  in  4  index of the picked card.
- card_addr  out  4  card ROM address (latched pick_idx).
- card_sym  in  3  card ROM data, combinational from card_addr.
- track_addr  out  5  track ROM address = (pos[turn]+1) mod TRACK_LEN.
- track_sym  in  3  track ROM data, combinational from track_addr.
- next_turn  out  1  one-cycle pulse to the rotator; registered, glitch-free.
- reveal_on  out  1  high while a card is revealed.
- pos_bus  out  20  four 5-bit chicken positions; player 0 in [4:0].
- winner_valid  out  1  high in WIN.
- winner_id  out  2  winning player index.
- busy  out  1  high in every state except IDLE, WAIT_PICK and WIN.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State = IDLE; positions = 0; step counters = 0; revealed mask = 0.
  - Reset mid-game aborts immediately with no `next_turn` pulse.
- States: IDLE, WAIT_PICK, JUDGE, REVEAL, PASS, SETTLE, WIN.
- IDLE or WIN, `start` = 1:
  - Latch n_players.
  - Set pos[p] = p*START_GAP for all p; clear step counters and mask.
  - Go to WAIT_PICK.
- WAIT_PICK, `pick_valid` = 1:
  - Accepted only if pick_idx < NUM_CARDS and mask[pick_idx] = 0.
  - On accept: latch card_addr, set mask bit, go to JUDGE.
  - Rejected picks are ignored; state is unchanged.
- `pick_valid` in any state other than WAIT_PICK is ignored.
- JUDGE (1 cycle):
  - Compare card_sym with track_sym for player `turn`.
  - Match: pos[turn] = pos[turn]+1 mod TRACK_LEN; steps[turn]++.
  - In all cases go to REVEAL with reveal_on = 1 and the hold counter loaded.
- REVEAL: hold for REVEAL_CYCLES cycles, then take the first applicable exit:
  - If steps[turn] == WIN_STEPS: go to WIN; winner_id = turn.
  - Else if the pick was a match and the mask is not yet full: go to WAIT_PICK (same player continues).
  - Else (miss, or mask full): go to PASS.
- PASS (1 cycle):
  - next_turn = 1; reveal_on = 0; mask cleared.
  - Go to SETTLE.
- SETTLE (1 cycle):
  - Lets the rotator update `turn`.
  - Go to WAIT_PICK.
- Pulse latency:
  - A miss accepted at cycle T gives next_turn high at T+2+REVEAL_CYCLES.
  - The next pick is accepted no earlier than T+4+REVEAL_CYCLES.
- Exactly one next_turn pulse is issued per turn hand-off. next_turn is never asserted outside PASS.
- `turn` values >= the latched player count select no position; JUDGE then treats the pick as a miss.
- WIN:
  - winner_valid = 1; pos_bus is frozen.
  - Only `start` or `rst` leaves WIN.
- `start` in a state other than IDLE or WIN is ignored.
- Arithmetic: position wrap from TRACK_LEN-1 goes to 0. Step counters saturate at WIN_STEPS.

Test Plan:
- Reset then start with n_players=01 -> pos_bus = {0,12,6,0}; state WAIT_PICK; next_turn=0; winner_valid=0.
- turn=0, pick matches track tile 1 -> JUDGE then pos[0]=1; reveal_on high for 8 cycles; return to WAIT_PICK; no next_turn pulse.
- turn=0, pick mismatches -> pos is unchanged; next_turn high for exactly 1 cycle, 10 cycles after the accept; next pick accepted no earlier than 12 cycles after the accept.
- Invalid and duplicate picks:
  - pick_idx=13 -> ignored.
  - The same idx picked twice in one turn -> the second pick is ignored.
  - pick_valid during REVEAL -> ignored.
  - Pick from a fresh turn after PASS -> accepted.
- Wrap and win:
  - Preload via a match sequence with pos=23 -> a match wraps pos to 0.
  - 24th match -> WIN; winner_valid=1; winner_id=turn; further picks are ignored.
- Reset asserted during REVEAL of a miss -> outputs 0 immediately; no next_turn pulse; `start` afterwards behaves as a fresh game.

Source files
------------

// File: rtl/turn_controller.sv
// Chicken Cha-Cha-Cha game-flow controller: judges card picks against
// the track tile ahead of the current chicken and hands turns over.
module turn_controller #(
  parameter int NUM_CARDS     = 12,
  parameter int TRACK_LEN     = 24,
  parameter int START_GAP     = 6,
  parameter int WIN_STEPS     = 24,
  parameter int REVEAL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  n_players,
  input  logic [1:0]  turn,
  input  logic        pick_valid,
  input  logic [3:0]  pick_idx,
  output logic [3:0]  card_addr,
  input  logic [2:0]  card_sym,
  output logic [4:0]  track_addr,
  input  logic [2:0]  track_sym,
  output logic        next_turn,
  output logic        reveal_on,
  output logic [19:0] pos_bus,
  output logic        winner_valid,
  output logic [1:0]  winner_id,
  output logic        busy
);

  localparam int HW =
    (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam int SW = $clog2(WIN_STEPS + 1);
  localparam logic [4:0] LAST = 5'(TRACK_LEN - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(WIN_STEPS);
  localparam logic [HW-1:0] HOLD_LD = HW'(REVEAL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_JUDGE,
    S_REVEAL,
    S_PASS,
    S_SETTLE,
    S_WIN
  } state_t;

  state_t               state;
  logic [4:0]           pos [4];
  logic [SW-1:0]        steps [4];
  logic [NUM_CARDS-1:0] mask;
  logic [HW-1:0]        hold;
  logic                 hit;
  logic [2:0]           np;

  logic [2:0] np_in;
  logic [4:0] cur_pos;
  logic [4:0] tile;
  logic       turn_ok;
  logic       taken;
  logic       pick_ok;
  logic       match;
  logic       won;
  logic       full;

  always_comb begin
    unique case (n_players)
      2'd0:    np_in = 3'd2;
      2'd1:    np_in = 3'd3;
      default: np_in = 3'd4;
    endcase
  end

  // A turn index outside the active player set selects no tile
  assign turn_ok    = {1'b0, turn} < np;
  assign cur_pos    = pos[turn];
  assign tile       = (cur_pos == LAST) ? 5'd0 : cur_pos + 5'd1;
  assign track_addr = turn_ok ? tile : 5'd0;
  assign match      = turn_ok && (card_sym == track_sym);
  assign won        = turn_ok && (steps[turn] == STEP_MAX);
  assign full       = &mask;
  assign pos_bus    = {pos[3], pos[2], pos[1], pos[0]};

  always_comb begin
    taken = 1'b0;
    for (int i = 0; i < NUM_CARDS; i++)
      if (pick_idx == 4'(i)) taken = mask[i];
  end

  assign pick_ok = pick_valid
                && (32'(pick_idx) < NUM_CARDS)
                && !taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mask         <= '0;
      hold         <= '0;
      hit          <= 1'b0;
      np           <= 3'd0;
      card_addr    <= 4'd0;
      next_turn    <= 1'b0;
      reveal_on    <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= 2'd0;
      busy         <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        pos[p]   <= 5'd0;
        steps[p] <= '0;
      end
    end else begin
      next_turn <= 1'b0;
      unique case (state)
        S_IDLE, S_WIN: begin
          if (start) begin
            np           <= np_in;
            mask         <= '0;
            winner_valid <= 1'b0;
            winner_id    <= 2'd0;
            state        <= S_WAIT;
            for (int p = 0; p < 4; p++) begin
              pos[p]   <= (3'(p) < np_in) ? 5'(p * START_GAP) : 5'd0;
              steps[p] <= '0;
            end
          end
        end
        S_WAIT: begin
          if (pick_ok) begin
            card_addr <= pick_idx;
            busy      <= 1'b1;
            state     <= S_JUDGE;
            for (int i = 0; i < NUM_CARDS; i++)
              if (pick_idx == 4'(i)) mask[i] <= 1'b1;
          end
        end
        S_JUDGE: begin
          hit       <= match;
          hold      <= HOLD_LD;
          reveal_on <= 1'b1;
          state     <= S_REVEAL;
          if (match) begin
            pos[turn] <= tile;
            if (steps[turn] != STEP_MAX)
              steps[turn] <= steps[turn] + 1'b1;
          end
        end
        S_REVEAL: begin
          if (hold != '0) begin
            hold <= hold - 1'b1;
          end else begin
            reveal_on <= 1'b0;
            if (won) begin
              winner_valid <= 1'b1;
              winner_id    <= turn;
              busy         <= 1'b0;
              state        <= S_WIN;
            end else if (hit && !full) begin
              busy  <= 1'b0;
              state <= S_WAIT;
            end else begin
              next_turn <= 1'b1;
              state     <= S_PASS;
            end
          end
        end
        S_PASS: begin
          mask  <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          busy  <= 1'b0;
          state <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Randomized self-checking bench for turn_controller with a
// game-level reference model and a simple turn rotator.
module tb_turn_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  n_players = 2'd0;
  logic [1:0]  turn;
  logic        pick_valid = 1'b0;
  logic [3:0]  pick_idx = 4'd0;
  logic [3:0]  card_addr;
  logic [2:0]  card_sym;
  logic [4:0]  track_addr;
  logic [2:0]  track_sym;
  logic        next_turn;
  logic        reveal_on;
  logic [19:0] pos_bus;
  logic        winner_valid;
  logic [1:0]  winner_id;
  logic        busy;
  logic        rot_clear = 1'b0;

  logic [2:0] card_rom [16];
  logic [2:0] track_rom [32];

  int  m_np = 0;
  int  m_turn = 0;
  int  m_pos [4];
  int  m_steps [4];
  int  m_addr = 0;
  int  m_winner = 0;
  bit  m_won = 1'b0;
  bit  used [12];

  int errs = 0;
  int checks = 0;

  turn_controller dut (
    .clk(clk), .rst(rst), .start(start), .n_players(n_players),
    .turn(turn), .pick_valid(pick_valid), .pick_idx(pick_idx),
    .card_addr(card_addr), .card_sym(card_sym),
    .track_addr(track_addr), .track_sym(track_sym),
    .next_turn(next_turn), .reveal_on(reveal_on), .pos_bus(pos_bus),
    .winner_valid(winner_valid), .winner_id(winner_id), .busy(busy)
  );

  always #5 clk = ~clk;

  assign card_sym  = card_rom[card_addr];
  assign track_sym = track_rom[track_addr];

  // Turn rotator as the environment sees it
  always @(posedge clk or posedge rst) begin
    if (rst) turn <= 2'd0;
    else if (rot_clear) turn <= 2'd0;
    else if (next_turn)
      turn <= (int'(turn) == m_np - 1) ? 2'd0 : turn + 2'd1;
  end

  function automatic logic [19:0] exp_bus();
    return {5'(m_pos[3]), 5'(m_pos[2]), 5'(m_pos[1]), 5'(m_pos[0])};
  endfunction

  task automatic model_start(input int n);
    m_np = (n == 0) ? 2 : (n == 1) ? 3 : 4;
    for (int p = 0; p < 4; p++) begin
      m_pos[p]   = (p < m_np) ? p * 6 : 0;
      m_steps[p] = 0;
    end
    for (int i = 0; i < 12; i++) used[i] = 1'b0;
    m_turn = 0;
    m_won  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_addr = 0;
    m_won  = 1'b0;
  endtask

  task automatic do_start(input int n);
    model_start(n);
    @(negedge clk);
    start = 1'b1; n_players = 2'(n); rot_clear = 1'b1;
    @(negedge clk);
    start = 1'b0; rot_clear = 1'b0;
  endtask

  // want: 1 force match, 0 force miss, -1 leave ROM as is
  task automatic pick(input int idx, input int want);
    int t, tile, rev_n, nt_n, nt_k, idle_k, inj, r0;
    bit acc, hit, win, pass, full;
    t = m_turn;
    acc = !m_won && idx < 12 && !used[idx];
    if (idx < 12 && want >= 0 && t < m_np) begin
      tile = (m_pos[t] + 1) % 24;
      card_rom[idx] = want ? track_rom[tile] : track_rom[tile] ^ 3'd1;
    end
    @(negedge clk);
    pick_valid = 1'b1; pick_idx = 4'(idx);
    @(posedge clk);
    if (!acc) begin
      @(negedge clk);
      pick_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errs++;
        $display("FAIL reject_busy idx=%0d: got %b want 0", idx, busy); end
      checks++;
      if (card_addr !== 4'(m_addr)) begin errs++;
        $display("FAIL reject_addr idx=%0d: got %0d want %0d", idx, card_addr, m_addr); end
      checks++;
      if (pos_bus !== exp_bus()) begin errs++;
        $display("FAIL reject_pos idx=%0d: got %h want %h", idx, pos_bus, exp_bus()); end
      return;
    end
    hit = (t < m_np) && (card_rom[idx] == track_rom[(m_pos[t] + 1) % 24]);
    used[idx] = 1'b1;
    m_addr = idx;
    if (hit) begin
      m_pos[t] = (m_pos[t] + 1) % 24;
      if (m_steps[t] < 24) m_steps[t]++;
    end
    win = (m_steps[t] == 24);
    full = 1'b1;
    for (int i = 0; i < 12; i++) if (!used[i]) full = 1'b0;
    pass = !win && (!hit || full);
    inj = -1;
    r0 = $urandom_range(0, 11);
    for (int i = 0; i < 12; i++)
      if (inj < 0 && !used[(r0 + i) % 12]) inj = (r0 + i) % 12;
    if (pass) begin
      for (int i = 0; i < 12; i++) used[i] = 1'b0;
      m_turn = (t + 1) % m_np;
    end
    if (win) begin m_won = 1'b1; m_winner = t; end
    rev_n = 0; nt_n = 0; nt_k = 0; idle_k = 99;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (reveal_on === 1'b1) rev_n++;
      if (next_turn === 1'b1) begin nt_n++; nt_k = k; end
      if (busy === 1'b0 && idle_k == 99) idle_k = k;
      pick_valid = 1'b0;
      if (k == 3 && inj >= 0) begin pick_valid = 1'b1; pick_idx = 4'(inj); end
      if (k == 11 && (pass || win)) begin pick_valid = 1'b1; pick_idx = 4'(idx); end
    end
    pick_valid = 1'b0;
    checks++;
    if (rev_n != 8) begin errs++;
      $display("FAIL reveal_len idx=%0d: got %0d want 8", idx, rev_n); end
    checks++;
    if (nt_n != int'(pass)) begin errs++;
      $display("FAIL next_turn_count idx=%0d: got %0d want %0d", idx, nt_n, pass); end
    if (pass) begin
      checks++;
      if (nt_k != 10) begin errs++;
        $display("FAIL next_turn_lat idx=%0d: got %0d want 10", idx, nt_k); end
    end
    checks++;
    if (idle_k != (pass ? 12 : 10)) begin errs++;
      $display("FAIL busy_drop idx=%0d: got %0d want %0d", idx, idle_k, pass ? 12 : 10); end
    checks++;
    if (busy !== 1'b0) begin errs++;
      $display("FAIL busy_end idx=%0d: got %b want 0", idx, busy); end
    checks++;
    if (pos_bus !== exp_bus()) begin errs++;
      $display("FAIL pos_bus idx=%0d: got %h want %h", idx, pos_bus, exp_bus()); end
    checks++;
    if (winner_valid !== m_won) begin errs++;
      $display("FAIL winner_valid idx=%0d: got %b want %b", idx, winner_valid, m_won); end
    if (m_won) begin
      checks++;
      if (winner_id !== 2'(m_winner)) begin errs++;
        $display("FAIL winner_id: got %0d want %0d", winner_id, m_winner); end
    end
    checks++;
    if (turn !== 2'(m_turn)) begin errs++;
      $display("FAIL turn idx=%0d: got %0d want %0d", idx, turn, m_turn); end
    checks++;
    if (card_addr !== 4'(idx)) begin errs++;
      $display("FAIL card_addr: got %0d want %0d", card_addr, idx); end
  endtask

  task automatic test_reset();
    checks++;
    if (next_turn !== 1'b0) begin errs++; $display("FAIL rst_next_turn: got %b want 0", next_turn); end
    checks++;
    if (reveal_on !== 1'b0) begin errs++; $display("FAIL rst_reveal: got %b want 0", reveal_on); end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (pos_bus !== 20'd0) begin errs++; $display("FAIL rst_pos: got %h want 0", pos_bus); end
    checks++;
    if (winner_valid !== 1'b0) begin errs++; $display("FAIL rst_win: got %b want 0", winner_valid); end
    checks++;
    if (winner_id !== 2'd0) begin errs++; $display("FAIL rst_winid: got %0d want 0", winner_id); end
    checks++;
    if (card_addr !== 4'd0) begin errs++; $display("FAIL rst_card_addr: got %0d want 0", card_addr); end
    checks++;
    if (track_addr !== 5'd0) begin errs++; $display("FAIL rst_track_addr: got %0d want 0", track_addr); end
  endtask

  task automatic test_start();
    do_start(1);
    @(negedge clk);
    checks++;
    if (pos_bus !== {5'd0, 5'd12, 5'd6, 5'd0}) begin errs++;
      $display("FAIL start_pos: got %h want %h", pos_bus, {5'd0, 5'd12, 5'd6, 5'd0}); end
    checks++;
    if (busy !== 1'b0 || next_turn !== 1'b0 || winner_valid !== 1'b0) begin errs++;
      $display("FAIL start_flags: got %b%b%b want 000", busy, next_turn, winner_valid); end
    checks++;
    if (track_addr !== 5'd1) begin errs++;
      $display("FAIL start_track_addr: got %0d want 1", track_addr); end
  endtask

  task automatic test_directed();
    pick(0, 1);
    pick(13, -1);
    pick(0, -1);
    pick(1, 0);
    pick(0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      pick($urandom_range(0, 15), $urandom_range(0, 2) - 1);
  endtask

  task automatic test_start_ignored();
    if (!m_won) begin
      @(negedge clk);
      start = 1'b1; n_players = 2'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (pos_bus !== exp_bus() || busy !== 1'b0) begin errs++;
        $display("FAIL start_ignored: got %h/%b want %h/0", pos_bus, busy, exp_bus()); end
    end
  endtask

  task automatic test_win();
    do_reset();
    do_start(0);
    for (int i = 0; i < 12; i++) pick(i, 1);
    pick(0, 0);
    for (int i = 0; i < 12; i++) pick(i, 1);
    checks++;
    if (pos_bus[4:0] !== 5'd0 || winner_valid !== 1'b1) begin errs++;
      $display("FAIL win_wrap: got pos %0d win %b want 0 1", pos_bus[4:0], winner_valid); end
    pick(3, -1);
  endtask

  task automatic test_reset_mid();
    int nt;
    do_start(1);
    card_rom[5] = track_rom[1] ^ 3'd1;
    @(negedge clk);
    pick_valid = 1'b1; pick_idx = 4'd5;
    @(negedge clk);
    pick_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({next_turn, reveal_on, busy, winner_valid} !== 4'b0) begin errs++;
      $display("FAIL mid_rst_flags: got %b want 0000", {next_turn, reveal_on, busy, winner_valid}); end
    checks++;
    if ({pos_bus, card_addr, track_addr, winner_id} !== 31'd0) begin errs++;
      $display("FAIL mid_rst_regs: got %h want 0", {pos_bus, card_addr, track_addr, winner_id}); end
    nt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (next_turn !== 1'b0) nt++;
    end
    checks++;
    if (nt != 0) begin errs++;
      $display("FAIL mid_rst_pulse: got %0d want 0", nt); end
    m_addr = 0;
    do_start(1);
    @(negedge clk);
    checks++;
    if (pos_bus !== exp_bus()) begin errs++;
      $display("FAIL mid_rst_restart: got %h want %h", pos_bus, exp_bus()); end
    pick(5, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) card_rom[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 32; i++) track_rom[i] = 3'($urandom_range(0, 7));
    for (int p = 0; p < 4; p++) begin m_pos[p] = 0; m_steps[p] = 0; end
    for (int i = 0; i < 12; i++) used[i] = 1'b0;
    do_reset();
    test_reset();
    test_start();
    test_directed();
    test_random();
    test_start_ignored();
    test_win();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
